// File: rtl/cylon_mem_pkg.sv
// Shared memory-subsystem types: arbiter states, requester indices, abort data.
package cylon_mem_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t WAIT = 2'd1;
    localparam arb_state_t DONE = 2'd2;

    localparam int unsigned REQ_VDP = 0;
    localparam int unsigned REQ_CPU = 1;
    localparam int unsigned REQ_APU = 2;

    // Read data returned on an aborted transaction, truncated to the bus width.
    localparam logic [63:0] RD_ABORT_DATA = '1;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Host port of sdram_controller: the arbiter is the master, the controller the slave.
interface sdram_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_din;
    logic          h_wr;
    logic          h_req;
    logic          h_ack;
    logic [DW-1:0] h_dout;

    modport master (output h_addr, h_din, h_wr, h_req, input h_ack, h_dout);
    modport slave  (input h_addr, h_din, h_wr, h_req, output h_ack, h_dout);
endinterface

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, with wrap-around.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_winner,
    output logic            o_any
);

    int              w_idx;
    logic [NREQ-1:0] w_bits;

    // Walk from farthest to nearest so the nearest candidate is written last.
    always_comb begin
        o_winner = '0;
        w_idx    = 0;
        w_bits   = '0;
        for (int i = int'(NREQ); i >= 1; i--) begin
            w_idx  = (int'(i_last) + i) % int'(NREQ);
            w_bits = i_req >> w_idx;
            if (w_bits[0]) o_winner = IW'(w_idx);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the sdram_controller host port between NREQ requesters, one transaction
// at a time, round-robin with a VDP urgency override and a stuck-controller timeout.
module sdram_port_arbiter
    import cylon_mem_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_din,
    input  logic               vdp_urgent,
    output logic [NREQ-1:0]    req_ack,
    output logic [DW-1:0]      rd_data,
    output logic               busy,
    output logic               timeout_err,
    sdram_port_arbiter_if.master host
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 8;

    arb_state_t      r_state, w_state_nx;
    logic [IW-1:0]   r_last, w_last_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
    logic [AW-1:0]   r_h_addr, w_h_addr_nx;
    logic [DW-1:0]   r_h_din, w_h_din_nx;
    logic            r_h_wr, w_h_wr_nx;
    logic            r_h_req, w_h_req_nx;
    logic [NREQ-1:0] r_req_ack, w_req_ack_nx;
    logic [DW-1:0]   r_rd_data, w_rd_data_nx;
    logic            r_busy, w_busy_nx;
    logic            r_terr, w_terr_nx;

    logic [IW-1:0]   w_pick, w_win;
    logic            w_any;
    logic [AW-1:0]   w_addr_sel;
    logic [DW-1:0]   w_din_sel;
    logic [NREQ-1:0] w_wr_bits;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .i_req    (req_valid),
        .i_last   (r_last),
        .o_winner (w_pick),
        .o_any    (w_any)
    );

    // An urgent VDP only overrides the rotation when it is actually requesting.
    assign w_win      = (vdp_urgent && req_valid[REQ_VDP]) ? IW'(REQ_VDP) : w_pick;
    assign w_addr_sel = AW'(req_addr >> (int'(w_win) * int'(AW)));
    assign w_din_sel  = DW'(req_din >> (int'(w_win) * int'(DW)));
    assign w_wr_bits  = req_wr >> w_win;
    assign w_cnt_inc  = r_cnt + CW'(1);

    always_comb begin
        w_state_nx   = r_state;
        w_last_nx    = r_last;
        w_cnt_nx     = r_cnt;
        w_h_addr_nx  = r_h_addr;
        w_h_din_nx   = r_h_din;
        w_h_wr_nx    = r_h_wr;
        w_h_req_nx   = r_h_req;
        w_req_ack_nx = '0;
        w_rd_data_nx = r_rd_data;
        w_terr_nx    = r_terr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_h_addr_nx = w_addr_sel;
                    w_h_din_nx  = w_din_sel;
                    w_h_wr_nx   = w_wr_bits[0];
                    w_h_req_nx  = 1'b1;
                    w_last_nx   = w_win;
                    w_cnt_nx    = '0;
                    w_state_nx  = WAIT;
                end
            end
            WAIT: begin
                // A completing ack takes priority over a timeout in the same cycle.
                if (host.h_ack) begin
                    w_h_req_nx   = 1'b0;
                    if (!r_h_wr) w_rd_data_nx = host.h_dout;
                    w_req_ack_nx = NREQ'(1) << r_last;
                    w_state_nx   = DONE;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_h_req_nx   = 1'b0;
                    w_terr_nx    = 1'b1;
                    w_rd_data_nx = DW'(RD_ABORT_DATA);
                    w_req_ack_nx = NREQ'(1) << r_last;
                    w_state_nx   = DONE;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        w_busy_nx = (w_state_nx != IDLE);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= IW'(NREQ - 1);
            r_cnt     <= '0;
            r_h_addr  <= '0;
            r_h_din   <= '0;
            r_h_wr    <= 1'b0;
            r_h_req   <= 1'b0;
            r_req_ack <= '0;
            r_rd_data <= '0;
            r_busy    <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_last    <= w_last_nx;
            r_cnt     <= w_cnt_nx;
            r_h_addr  <= w_h_addr_nx;
            r_h_din   <= w_h_din_nx;
            r_h_wr    <= w_h_wr_nx;
            r_h_req   <= w_h_req_nx;
            r_req_ack <= w_req_ack_nx;
            r_rd_data <= w_rd_data_nx;
            r_busy    <= w_busy_nx;
            r_terr    <= w_terr_nx;
        end
    end

    assign host.h_addr = r_h_addr;
    assign host.h_din  = r_h_din;
    assign host.h_wr   = r_h_wr;
    assign host.h_req  = r_h_req;
    assign req_ack     = r_req_ack;
    assign rd_data     = r_rd_data;
    assign busy        = r_busy;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter; the bench plays both the requesters and the controller.
module tb_sdram_port_arbiter;
    import cylon_mem_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 8;

    logic               clk_sys = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_din;
    logic               vdp_urgent;
    logic [NREQ-1:0]    req_ack;
    logic [DW-1:0]      rd_data;
    logic               busy;
    logic               timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] addr_tab [NREQ];
    logic [31:0] last_rd;

    sdram_port_arbiter_if #(.AW(AW), .DW(DW)) host_if ();

    sdram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_din     (req_din),
        .vdp_urgent  (vdp_urgent),
        .req_ack     (req_ack),
        .rd_data     (rd_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .host        (host_if)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Grant requester g, ack k cycles after h_req rises, then retire the request.
    task automatic do_txn(input int g, input int k, input logic [31:0] dout, input string tag);
        step();
        chk({tag, " h_req up"}, 32'(host_if.h_req), 32'd1);
        chk({tag, " grant addr"}, host_if.h_addr, addr_tab[g]);
        chk({tag, " h_wr"}, 32'(host_if.h_wr), 32'd0);
        for (int i = 0; i < k; i++) begin
            step();
            chk({tag, " no early ack"}, 32'(req_ack), 32'd0);
        end
        host_if.h_ack  = 1'b1;
        host_if.h_dout = dout;
        step();
        host_if.h_ack  = 1'b0;
        host_if.h_dout = '0;
        chk({tag, " req_ack"}, 32'(req_ack), 32'd1 << g);
        chk({tag, " rd_data"}, rd_data, dout);
        chk({tag, " h_req down"}, 32'(host_if.h_req), 32'd0);
        last_rd      = dout;
        req_valid[g] = 1'b0;
        step();
        chk({tag, " ack cleared"}, 32'(req_ack), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        addr_tab[0] = 32'h0000_0A00;
        addr_tab[1] = 32'h0000_0100;
        addr_tab[2] = 32'h0000_0C00;
        rst_n          = 1'b0;
        req_valid      = '0;
        req_wr         = '0;
        req_din        = '0;
        vdp_urgent     = 1'b0;
        host_if.h_ack  = 1'b0;
        host_if.h_dout = '0;
        last_rd        = '0;
        req_addr       = {addr_tab[2], addr_tab[1], addr_tab[0]};

        #12;
        chk("rst h_req", 32'(host_if.h_req), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req_ack", 32'(req_ack), 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        chk("rst timeout_err", 32'(timeout_err), 32'd0);
        chk("rst h_addr", host_if.h_addr, 32'd0);
        step();
        rst_n = 1'b1;

        // Single CPU read, ack 4 cycles after h_req rises.
        req_valid = 3'b010;
        do_txn(REQ_CPU, 4, 32'hCAFE_BABE, "single_rd");
        chk("rd_data held", rd_data, 32'hCAFE_BABE);

        // Stray ack while idle must be ignored.
        host_if.h_ack = 1'b1;
        step();
        host_if.h_ack = 1'b0;
        step();
        chk("stray ack req_ack", 32'(req_ack), 32'd0);
        chk("stray ack busy", 32'(busy), 32'd0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Round-robin with all three requesting continuously.
        req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            do_txn(n % 3, 1, 32'h5000_0000 + 32'(n), "rr");
            req_valid[n % 3] = 1'b1;
        end

        // Bring last_grant to 0, then urgent VDP beats CPU/APU.
        req_valid = 3'b001;
        do_txn(REQ_VDP, 1, 32'h0000_1111, "vdp_only");
        req_valid  = 3'b111;
        vdp_urgent = 1'b1;
        do_txn(REQ_VDP, 2, 32'h0000_2222, "urgent_vdp");
        do_txn(REQ_CPU, 1, 32'h0000_3333, "after_urgent_cpu");
        do_txn(REQ_APU, 1, 32'h0000_4444, "after_urgent_apu");
        // Urgent without a VDP request does not override the rotation.
        req_valid = 3'b110;
        do_txn(REQ_CPU, 1, 32'h0000_5555, "urgent_no_vdp");
        req_valid  = '0;
        vdp_urgent = 1'b0;
        step();

        // APU write: fields latched at grant, request dropped during WAIT.
        req_valid = 3'b100;
        req_wr    = 3'b100;
        req_din   = {32'hDEAD_BEEF, 64'd0};
        step();
        chk("wr h_req", 32'(host_if.h_req), 32'd1);
        chk("wr h_wr", 32'(host_if.h_wr), 32'd1);
        chk("wr h_din", host_if.h_din, 32'hDEAD_BEEF);
        req_valid = '0;
        req_wr    = '0;
        req_din   = '0;
        req_addr  = {32'h0000_0123, addr_tab[1], addr_tab[0]};
        step();
        chk("wr latched addr", host_if.h_addr, addr_tab[2]);
        chk("wr latched din", host_if.h_din, 32'hDEAD_BEEF);
        chk("wr latched wr", 32'(host_if.h_wr), 32'd1);
        host_if.h_ack  = 1'b1;
        host_if.h_dout = 32'h1111_1111;
        step();
        host_if.h_ack  = 1'b0;
        chk("wr req_ack", 32'(req_ack), 32'b100);
        chk("wr rd_data unchanged", rd_data, last_rd);
        step();
        chk("wr idle", 32'(busy), 32'd0);
        req_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};

        // Ack lands exactly when the counter reaches TIMEOUT: normal completion.
        req_valid = 3'b001;
        do_txn(REQ_VDP, 7, 32'hA5A5_A5A5, "ack_at_timeout");
        chk("ack_at_timeout no err", 32'(timeout_err), 32'd0);

        // No ack at all: abort after TIMEOUT cycles in WAIT.
        req_valid = 3'b010;
        step();
        chk("to h_req up", 32'(host_if.h_req), 32'd1);
        for (int i = 1; i < int'(TO); i++) step();
        chk("to h_req last wait", 32'(host_if.h_req), 32'd1);
        chk("to no ack yet", 32'(req_ack), 32'd0);
        step();
        chk("to h_req down", 32'(host_if.h_req), 32'd0);
        chk("to req_ack", 32'(req_ack), 32'b010);
        chk("to rd_data", rd_data, 32'hFFFF_FFFF);
        chk("to err set", 32'(timeout_err), 32'd1);
        req_valid = '0;
        step();
        step();
        chk("to err sticky", 32'(timeout_err), 32'd1);
        chk("to idle", 32'(busy), 32'd0);

        // Reset during WAIT clears outputs asynchronously.
        req_valid = 3'b111;
        step();
        step();
        chk("pre-rst h_req", 32'(host_if.h_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst h_req", 32'(host_if.h_req), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst req_ack", 32'(req_ack), 32'd0);
        chk("async rst err", 32'(timeout_err), 32'd0);
        step();
        chk("in rst req_ack", 32'(req_ack), 32'd0);
        rst_n = 1'b1;
        do_txn(REQ_VDP, 1, 32'h0BAD_F00D, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
